// File: rtl/spi_flash_reader.sv
// spi_flash_reader: turns one "read N bytes at A" request into a serial-flash READ over spi_master.
// Define SPI_FLASH_READER_FAST_READ_EN to send FAST_READ (8'h0B) with one dummy byte before data.
module spi_flash_reader #(
    parameter int         LEN_W     = 16,
    parameter int         CS_CYCLES = 2,
    parameter logic [7:0] CMD_READ  = 8'h03
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             cs_n,
    output logic             spi_req,
    input  logic             spi_ready,
    output logic [7:0]       spi_tx,
    input  logic             spi_done,
    input  logic [7:0]       spi_rx,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);
`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE  = 8'h0B;
    localparam bit         FAST_READ = 1'b1;
`else
    localparam logic [7:0] CMD_BYTE  = CMD_READ;
    localparam bit         FAST_READ = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, CS_SETUP, CMD, A2, A1, A0, DUMMY, DATA, CS_HOLD, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             pend_q, pend_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             issue, got, cnt_end;

    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign cs_n     = !(state_q inside {CS_SETUP, CMD, A2, A1, A0, DUMMY, DATA, CS_HOLD});
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    // data bytes are only requested once the previous one has been consumed
    assign issue    = (state_q inside {CMD, A2, A1, A0, DUMMY}) || (state_q == DATA && !rd_valid_q);
    assign spi_req  = issue && !pend_q;
    assign got      = spi_done && pend_q;
    assign cnt_end  = cnt_q == 4'(CS_CYCLES - 1);
    assign spi_tx   = state_q == CMD  ? CMD_BYTE :
                      state_q == A2   ? addr_q[23:16] :
                      state_q == A1   ? addr_q[15:8] :
                      state_q == A0   ? addr_q[7:0] :
                      state_q == DATA ? 8'hFF : 8'h00;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        pend_d     = pend_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (spi_req && spi_ready) pend_d = 1'b1;
        if (got) pend_d = 1'b0;
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = addr;
                rem_d   = len;
                cnt_d   = 4'd0;
                state_d = (len == '0) ? DONE : CS_SETUP;
            end
            CS_SETUP: begin
                cnt_d = cnt_end ? 4'd0 : cnt_q + 4'd1;
                if (cnt_end) state_d = CMD;
            end
            CMD:   if (got) state_d = A2;
            A2:    if (got) state_d = A1;
            A1:    if (got) state_d = A0;
            A0:    if (got) state_d = FAST_READ ? DUMMY : DATA;
            DUMMY: if (got) state_d = DATA;
            DATA: if (got) begin
                rd_data_d  = spi_rx;
                rd_valid_d = 1'b1;
                rem_d      = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = CS_HOLD;
            end
            CS_HOLD: begin
                cnt_d = cnt_end ? 4'd0 : cnt_q + 4'd1;
                if (cnt_end) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 24'h0;
            rem_q      <= '0;
            pend_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench with a loopback spi_master model returning 8'hA0+byte index.
module tb_spi_flash_reader;
    localparam int LEN_W = 16;
    localparam int CS    = 2;
`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] CB = 8'h0B;
    localparam int         DM = 1;
`else
    localparam logic [7:0] CB = 8'h03;
    localparam int         DM = 0;
`endif

    logic clk, rst, start, busy, done, cs_n, spi_req, spi_ready, spi_done, rd_valid, rd_ready;
    logic [23:0] addr;
    logic [LEN_W-1:0] len;
    logic [7:0] spi_tx, spi_rx, rd_data;

    spi_flash_reader #(.LEN_W(LEN_W), .CS_CYCLES(CS), .CMD_READ(8'h03)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len), .busy(busy), .done(done),
        .cs_n(cs_n), .spi_req(spi_req), .spi_ready(spi_ready), .spi_tx(spi_tx), .spi_done(spi_done),
        .spi_rx(spi_rx), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, lat = 0, idx = 0;
    int done_cnt, done_cyc, sd_cyc, st_cyc, cs_rises, cs_low, req_cs_high, req_vr;
    logic cs_prev = 1'b1;
    logic [7:0] tx_log[$], rx_log[$], exp_tx[$], exp_rx[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] e[$]);
        chk({tag, "_len"}, got.size(), e.size());
        foreach (e[i]) chk($sformatf("%s[%0d]", tag, i), i < got.size() ? {24'h0, got[i]} : 32'hDEAD, {24'h0, e[i]});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic mk_exp(input logic [23:0] a, input int n);
        exp_tx = '{CB, a[23:16], a[15:8], a[7:0]};
        if (DM != 0) exp_tx.push_back(8'h00);
        exp_rx = {};
        for (int k = 0; k < n; k++) begin
            exp_tx.push_back(8'hFF);
            exp_rx.push_back(8'(8'hA4 + DM + k));
        end
    endtask

    task automatic begin_tx(input logic [23:0] a, input logic [LEN_W-1:0] l);
        tx_log = {}; rx_log = {}; idx = 0;
        done_cnt = 0; done_cyc = 0; cs_rises = 0; cs_low = 0; req_cs_high = 0; req_vr = 0;
        addr = a; len = l; start = 1'b1; st_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 2000) begin tick(1); k++; end
        if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
        tick(5);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_log.size() < n && k < 500) begin tick(1); k++; end
        if (tx_log.size() < n) chk("tx_timeout", tx_log.size(), n);
    endtask

    // spi_master loopback model, consumer and monitors, all evaluated mid-cycle
    initial forever begin
        @(negedge clk);
        cyc++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cs_n && !cs_prev) cs_rises++;
        if (!cs_n) cs_low++;
        if (spi_req && cs_n) req_cs_high++;
        if (spi_req && rd_valid) req_vr++;
        cs_prev = cs_n;
        if (rd_valid && rd_ready) rx_log.push_back(rd_data);
        if (!rst) begin
            lat = 0; spi_done = 1'b0;
        end else begin
            if (spi_done) spi_done = 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin spi_done = 1'b1; spi_rx = 8'(8'hA0 + idx); idx++; sd_cyc = cyc; end
            end
            if (spi_req && spi_ready && lat == 0 && !spi_done) begin tx_log.push_back(spi_tx); lat = 2; end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; len = '0; spi_ready = 1'b1; rd_ready = 1'b1;
        spi_done = 1'b0; spi_rx = 8'h00;
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_req", spi_req, 0);
        chk("rst_tx", spi_tx, 8'h00);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 0);
        @(posedge clk); #2 rst = 1'b1;
        tick(2);

        begin_tx(24'h123456, 3);
        wait_done();
        mk_exp(24'h123456, 3);
        chk_q("norm_tx", tx_log, exp_tx);
        chk_q("norm_rx", rx_log, exp_rx);
        chk("norm_done_n", done_cnt, 1);
        chk("norm_done_t", done_cyc - sd_cyc, CS + 1);
        chk("norm_cs_rise", cs_rises, 1);
        chk("norm_req_cs_high", req_cs_high, 0);

        begin_tx(24'h654321, 0);
        wait_done();
        chk("zero_done_t", done_cyc - st_cyc, 2);
        chk("zero_done_n", done_cnt, 1);
        chk("zero_cs_low", cs_low, 0);
        chk("zero_req", tx_log.size(), 0);

        begin_tx(24'h000100, 4);
        begin
            int k = 0;
            while (rx_log.size() < 1 && k < 500) begin tick(1); k++; end
            if (rx_log.size() < 1) chk("bp_first_timeout", rx_log.size(), 1);
        end
        rd_ready = 1'b0;
        tick(50);
        chk("bp_stall_tx", tx_log.size(), 4 + DM + 2);
        chk("bp_held_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_done();
        mk_exp(24'h000100, 4);
        chk_q("bp_tx", tx_log, exp_tx);
        chk_q("bp_rx", rx_log, exp_rx);
        chk("bp_req_while_valid", req_vr, 0);

        begin_tx(24'h123456, 1);
        wait_tx(3);
        chk("busy_mid", busy, 1);
        addr = 24'hFFFFFF; len = 16'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done();
        tick(10);
        mk_exp(24'h123456, 1);
        chk_q("busy_tx", tx_log, exp_tx);
        chk("busy_done_n", done_cnt, 1);
        chk("busy_idle", busy, 0);

        begin_tx(24'h123456, 3);
        wait_tx(3);
        rst = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 1);
        chk("arst_req", spi_req, 0);
        chk("arst_busy", busy, 0);
        tick(2);
        rst = 1'b1;
        tick(5);
        chk("arst_no_done", done_cnt, 0);
        chk("arst_rd_valid", rd_valid, 0);
        begin_tx(24'hABCDEF, 2);
        wait_done();
        mk_exp(24'hABCDEF, 2);
        chk_q("arst_next_tx", tx_log, exp_tx);
        chk_q("arst_next_rx", rx_log, exp_rx);
        chk("arst_next_done_n", done_cnt, 1);

`ifdef SPI_FLASH_READER_FAST_READ_EN
        begin_tx(24'h000010, 2);
        wait_done();
        chk_q("fast_tx", tx_log, '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF});
        chk_q("fast_rx", rx_log, '{8'hA5, 8'hA6});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
